hazard_unit_nway: RTL and testbench
===================================

Name: hazard_unit_nway

Overview:
- Parametrised hazard controller for the N-lane in-order MIPS pipeline (F/D/E/M/W). Successor to the fixed two-lane controller.
- Produces E-stage and D-stage (branch compare) forwarding selects for any lane count.
- Detects load-use and branch-operand stalls, and runs a counter FSM that freezes the pipe for multi-cycle data-memory accesses.
- Keeps a stall-cycle performance counter. Sits beside the datapath; all pipeline-register enables and flushes come from here.

Parameters:
- LANES, 2, issue width (1..4)
- REGW, 5, register-specifier width
- MEM_LAT, 1, data-memory access latency in cycles (1 = no memory stall)
- CNTW, 32, performance-counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rs_d, rt_d  in  LANES*REGW  D-stage source specifiers; lane k at bits [k*REGW +: REGW]
- branch_d  in  LANES  D-stage lane holds a branch
- rs_e, rt_e  in  LANES*REGW  E-stage source specifiers
- writereg_e, writereg_m, writereg_w  in  LANES*REGW  destination specifier per stage/lane
- regwrite_e, regwrite_m, regwrite_w  in  LANES  lane writes the register file
- memtoreg_e, memtoreg_m  in  LANES  lane is a load
- memwrite_m  in  LANES  lane is a store
- stall_f, stall_d, stall_e, stall_m  out  1  hold the pipeline register feeding that stage
- flush_e, flush_w  out  1  insert a bubble into E / W
- fwd_a_e, fwd_b_e  out  LANES*FSE  E-operand select; FSE = $clog2(2*LANES+1)
- fwd_a_d, fwd_b_d  out  LANES*FSD  D branch-compare select; FSD = $clog2(LANES+1)
- stall_count  out  CNTW  cycles with stall_f high since reset

Behaviour:
- Register 0 never matches in any comparison.
- E-select encoding:
  - 0 = register file
  - 1+k = M lane k
  - 1+LANES+k = W lane k
  - Priority: any M match beats any W match; within a stage the higher lane index (younger) wins.
- D-select encoding: 0 = register file, 1+k = M lane k with regwrite_m[k] && !memtoreg_m[k]. Highest matching lane wins.
- All selects are combinational and independent of stall state.
- Load-use stall (lu): any lane j in D, any lane k in E with memtoreg_e[k] && writereg_e[k] in {rs_d[j], rt_d[j]}.
- Branch stall (bs), for any D lane with branch_d set:
  - an E lane k with regwrite_e[k] writes its rs or rt, or
  - an M lane k with memtoreg_m[k] writes its rs or rt.
- Memory FSM, states IDLE and WAIT, with a down-counter cnt of width $clog2(MEM_LAT)+1:
  - IDLE: if MEM_LAT>1 and any (memtoreg_m|memwrite_m), assert ms this cycle; next state WAIT, cnt <= MEM_LAT-2.
  - WAIT: ms = (cnt!=0); cnt decrements while nonzero. When cnt==0, ms is low, the M instruction advances this edge, and the FSM returns to IDLE.
  - A new memory op entering M after release is detected afresh in IDLE. Total stall per access is exactly MEM_LAT-1 cycles.
  - With MEM_LAT==1 the FSM stays in IDLE and ms is never asserted.
- Output combination:
  - ms=1: stall_f=stall_d=stall_e=stall_m=1, flush_w=1, flush_e=0. ms overrides lu/bs; E is frozen, not flushed.
  - otherwise: stall_f=stall_d=flush_e=(lu|bs); stall_e=stall_m=flush_w=0.
- stall_count increments on every clock where stall_f=1, wraps at 2^CNTW, and is cleared by rst.
- Reset:
  - while rst is high, all stall/flush outputs are 0 and all fwd selects are 0.
  - at the rst edge: state=IDLE, cnt=0, stall_count=0.
  - rst asserted in WAIT aborts the stall immediately.

Decomposition:
- Package hazard_pkg: FSM state enum (IDLE/WAIT), functions fse_w(LANES)/fsd_w(LANES), and a select-encode helper function.
- One natural sub-module: mem_stall_fsm (MEM_LAT, clk, rst, mem_op_m -> ms). Priority-match logic is kept inline in generate loops.

Test Plan:
- LANES=2, regwrite_m[1], writereg_m[1]=8, rs_e[0]=8, regwrite_w[0] with writereg_w[0]=8 -> fwd_a_e lane0 = 2 (M lane1 beats W).
- memtoreg_e[0]=1, writereg_e[0]=9, rt_d[1]=9 -> stall_f=stall_d=flush_e=1 for one cycle; stall_count +1.
- branch_d[0]=1, rs_d[0]=4, regwrite_e[1]=1, writereg_e[1]=4 -> bs: stall_f=1, flush_e=1. Next cycle the producer is in M (non-load) -> fwd_a_d lane0 = 2, no stall.
- MEM_LAT=3, memwrite_m[0]=1 -> ms high exactly 2 cycles, flush_w=1 both cycles, stall_count += 2. A second store immediately after -> another 2-cycle stall.
- MEM_LAT=3 with a load in M and lu true simultaneously -> flush_e=0 during ms; after release, lu handling resumes.
- rst pulsed during WAIT -> next cycle all stalls 0, stall_count=0, FSM in IDLE. Any writereg=0 match -> fwd selects 0.

Source files
------------

// File: rtl/hazard_unit_nway_pkg.sv
// Shared types and width helpers for the N-lane hazard controller.
package hazard_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  function automatic int fse_w(input int lanes);
    return $clog2(2 * lanes + 1);
  endfunction

  function automatic int fsd_w(input int lanes);
    return $clog2(lanes + 1);
  endfunction

  // Forwarding select code: 0 = register file, then M lanes, then W lanes.
  function automatic int sel_enc(input bit from_w, input int lane, input int lanes);
    return from_w ? (1 + lanes + lane) : (1 + lane);
  endfunction

endpackage

// File: rtl/hazard_unit_nway_if.sv
// Pipeline-side bundle between the datapath (master) and the hazard unit (slave).
interface hazard_unit_nway_if #(
  parameter int LANES = 2,
  parameter int REGW  = 5,
  parameter int CNTW  = 32
);
  import hazard_pkg::*;

  localparam int FSE = fse_w(LANES);
  localparam int FSD = fsd_w(LANES);

  logic [LANES*REGW-1:0] rs_d, rt_d, rs_e, rt_e;
  logic [LANES*REGW-1:0] writereg_e, writereg_m, writereg_w;
  logic [LANES-1:0]      branch_d;
  logic [LANES-1:0]      regwrite_e, regwrite_m, regwrite_w;
  logic [LANES-1:0]      memtoreg_e, memtoreg_m, memwrite_m;

  logic                  stall_f, stall_d, stall_e, stall_m;
  logic                  flush_e, flush_w;
  logic [LANES*FSE-1:0]  fwd_a_e, fwd_b_e;
  logic [LANES*FSD-1:0]  fwd_a_d, fwd_b_d;
  logic [CNTW-1:0]       stall_count;

  modport master (
    output rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w,
    output branch_d, regwrite_e, regwrite_m, regwrite_w,
    output memtoreg_e, memtoreg_m, memwrite_m,
    input  stall_f, stall_d, stall_e, stall_m, flush_e, flush_w,
    input  fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d, stall_count
  );

  modport slave (
    input  rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w,
    input  branch_d, regwrite_e, regwrite_m, regwrite_w,
    input  memtoreg_e, memtoreg_m, memwrite_m,
    output stall_f, stall_d, stall_e, stall_m, flush_e, flush_w,
    output fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d, stall_count
  );

endinterface

// File: rtl/hazard_unit_nway_mem_stall_fsm.sv
// Freezes the pipe for MEM_LAT-1 cycles whenever a load/store sits in M.
//   state | meaning
//   IDLE  | no access in flight; a new M-stage memory op raises ms at once
//   WAIT  | access in flight; ms while cnt != 0, release and return when cnt == 0
module mem_stall_fsm
  import hazard_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_op_m_i,
  output logic ms_o
);

  localparam int         CW     = $clog2(MEM_LAT) + 1;
  localparam bit         HAS_MS = (MEM_LAT > 1);
  localparam logic [CW-1:0] RELOAD = CW'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);

  mem_state_e      state_q;
  logic [CW-1:0]   cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (HAS_MS && mem_op_m_i) begin
            state_q <= WAIT;
            cnt_q   <= RELOAD;
          end
        end
        WAIT: begin
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
          else             state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ms must be visible in the same cycle the op reaches M, so it is decoded, not registered.
  always_comb begin
    ms_o = 1'b0;
    if (!rst) begin
      if (state_q == IDLE) ms_o = HAS_MS && mem_op_m_i;
      else                 ms_o = (cnt_q != '0);
    end
  end

endmodule

// File: rtl/hazard_unit_nway.sv
// N-lane hazard controller: forwarding selects, load-use/branch stalls,
// multi-cycle memory freeze and a stall-cycle counter.
module hazard_unit_nway
  import hazard_pkg::*;
#(
  parameter int LANES   = 2,
  parameter int REGW    = 5,
  parameter int MEM_LAT = 1,
  parameter int CNTW    = 32
) (
  input  logic              clk,
  input  logic              rst,
  hazard_unit_nway_if.slave hz
);

  localparam int FSE = fse_w(LANES);
  localparam int FSD = fsd_w(LANES);

  logic [LANES*FSE-1:0] fa_e, fb_e;
  logic [LANES*FSD-1:0] fa_d, fb_d;
  logic                 lu, bs, lub, ms;
  logic [CNTW-1:0]      stall_count_q, stall_count_d;

  function automatic logic hit(input logic [REGW-1:0] src, input logic [REGW-1:0] dst,
                               input logic we);
    return we && (dst != '0) && (dst == src);
  endfunction

  // Ascending lane order with M after W: later assignments win, giving M over W and younger over older.
  always_comb begin
    fa_e = '0;
    fb_e = '0;
    fa_d = '0;
    fb_d = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int k = 0; k < LANES; k++) begin
        if (hit(hz.rs_e[i*REGW +: REGW], hz.writereg_w[k*REGW +: REGW], hz.regwrite_w[k]))
          fa_e[i*FSE +: FSE] = FSE'(sel_enc(1'b1, k, LANES));
        if (hit(hz.rt_e[i*REGW +: REGW], hz.writereg_w[k*REGW +: REGW], hz.regwrite_w[k]))
          fb_e[i*FSE +: FSE] = FSE'(sel_enc(1'b1, k, LANES));
      end
      for (int k = 0; k < LANES; k++) begin
        if (hit(hz.rs_e[i*REGW +: REGW], hz.writereg_m[k*REGW +: REGW], hz.regwrite_m[k]))
          fa_e[i*FSE +: FSE] = FSE'(sel_enc(1'b0, k, LANES));
        if (hit(hz.rt_e[i*REGW +: REGW], hz.writereg_m[k*REGW +: REGW], hz.regwrite_m[k]))
          fb_e[i*FSE +: FSE] = FSE'(sel_enc(1'b0, k, LANES));
        if (hit(hz.rs_d[i*REGW +: REGW], hz.writereg_m[k*REGW +: REGW],
                hz.regwrite_m[k] && !hz.memtoreg_m[k]))
          fa_d[i*FSD +: FSD] = FSD'(sel_enc(1'b0, k, LANES));
        if (hit(hz.rt_d[i*REGW +: REGW], hz.writereg_m[k*REGW +: REGW],
                hz.regwrite_m[k] && !hz.memtoreg_m[k]))
          fb_d[i*FSD +: FSD] = FSD'(sel_enc(1'b0, k, LANES));
      end
    end
  end

  always_comb begin
    lu = 1'b0;
    bs = 1'b0;
    for (int j = 0; j < LANES; j++) begin
      for (int k = 0; k < LANES; k++) begin
        if (hit(hz.rs_d[j*REGW +: REGW], hz.writereg_e[k*REGW +: REGW], hz.memtoreg_e[k]) ||
            hit(hz.rt_d[j*REGW +: REGW], hz.writereg_e[k*REGW +: REGW], hz.memtoreg_e[k]))
          lu = 1'b1;
        if (hz.branch_d[j] &&
            (hit(hz.rs_d[j*REGW +: REGW], hz.writereg_e[k*REGW +: REGW], hz.regwrite_e[k]) ||
             hit(hz.rt_d[j*REGW +: REGW], hz.writereg_e[k*REGW +: REGW], hz.regwrite_e[k]) ||
             hit(hz.rs_d[j*REGW +: REGW], hz.writereg_m[k*REGW +: REGW], hz.memtoreg_m[k]) ||
             hit(hz.rt_d[j*REGW +: REGW], hz.writereg_m[k*REGW +: REGW], hz.memtoreg_m[k])))
          bs = 1'b1;
      end
    end
  end

  mem_stall_fsm #(.MEM_LAT(MEM_LAT)) u_mem_stall_fsm (
    .clk        (clk),
    .rst        (rst),
    .mem_op_m_i (|(hz.memtoreg_m | hz.memwrite_m)),
    .ms_o       (ms)
  );

  assign lub = !rst && (lu || bs);

  // A memory freeze holds E in place, so it must not also bubble it.
  assign hz.stall_f = ms || lub;
  assign hz.stall_d = ms || lub;
  assign hz.flush_e = !ms && lub;
  assign hz.stall_e = ms;
  assign hz.stall_m = ms;
  assign hz.flush_w = ms;

  assign hz.fwd_a_e = rst ? '0 : fa_e;
  assign hz.fwd_b_e = rst ? '0 : fb_e;
  assign hz.fwd_a_d = rst ? '0 : fa_d;
  assign hz.fwd_b_d = rst ? '0 : fb_d;

  assign stall_count_d = stall_count_q + CNTW'(hz.stall_f);

  always_ff @(posedge clk) begin
    if (rst) stall_count_q <= '0;
    else     stall_count_q <= stall_count_d;
  end

  assign hz.stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_unit_nway.sv
// Directed bench: LANES=2 hazard unit with MEM_LAT=3, plus a MEM_LAT=1 twin.
module tb_hazard_unit_nway;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hazard_unit_nway_if #(.LANES(2), .REGW(5), .CNTW(32)) hif  ();
  hazard_unit_nway_if #(.LANES(2), .REGW(5), .CNTW(32)) hif1 ();

  hazard_unit_nway #(.LANES(2), .REGW(5), .MEM_LAT(3), .CNTW(32)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hif)
  );

  hazard_unit_nway #(.LANES(2), .REGW(5), .MEM_LAT(1), .CNTW(32)) dut1 (
    .clk (clk),
    .rst (rst),
    .hz  (hif1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    hif.rs_d = '0; hif.rt_d = '0; hif.rs_e = '0; hif.rt_e = '0;
    hif.writereg_e = '0; hif.writereg_m = '0; hif.writereg_w = '0;
    hif.branch_d = '0; hif.regwrite_e = '0; hif.regwrite_m = '0; hif.regwrite_w = '0;
    hif.memtoreg_e = '0; hif.memtoreg_m = '0; hif.memwrite_m = '0;
  endtask

  task automatic clr1();
    hif1.rs_d = '0; hif1.rt_d = '0; hif1.rs_e = '0; hif1.rt_e = '0;
    hif1.writereg_e = '0; hif1.writereg_m = '0; hif1.writereg_w = '0;
    hif1.branch_d = '0; hif1.regwrite_e = '0; hif1.regwrite_m = '0; hif1.regwrite_w = '0;
    hif1.memtoreg_e = '0; hif1.memtoreg_m = '0; hif1.memwrite_m = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ms(input string tag, input logic exp_ms);
    chk({tag, "_stall_f"}, hif.stall_f, exp_ms);
    chk({tag, "_stall_m"}, hif.stall_m, exp_ms);
    chk({tag, "_flush_w"}, hif.flush_w, exp_ms);
  endtask

  initial begin
    rst = 1'b1;
    clr();
    clr1();
    // Hazards presented during reset must be masked.
    hif.memtoreg_e = 2'b01; hif.writereg_e[0 +: 5] = 5'd9; hif.rs_d[0 +: 5] = 5'd9;
    hif.regwrite_m = 2'b01; hif.writereg_m[0 +: 5] = 5'd3; hif.rs_e[0 +: 5] = 5'd3;
    @(negedge clk);
    chk("rst_stall_f", hif.stall_f, 1'b0);
    chk("rst_flush_e", hif.flush_e, 1'b0);
    chk("rst_fwd_a_e", hif.fwd_a_e, 6'd0);
    chk("rst_count",   hif.stall_count, 32'd0);
    step();
    rst = 1'b0;
    clr();

    // M lane1 beats W lane0
    hif.regwrite_m = 2'b10; hif.writereg_m[5 +: 5] = 5'd8;
    hif.rs_e[0 +: 5] = 5'd8;
    hif.regwrite_w = 2'b01; hif.writereg_w[0 +: 5] = 5'd8;
    @(negedge clk);
    chk("fwd_m_over_w", hif.fwd_a_e, 6'd2);
    chk("fwd_m_nostall", hif.stall_f, 1'b0);
    step();

    // W only: younger W lane1 wins -> 1+2+1 = 4
    clr();
    hif.regwrite_w = 2'b11; hif.writereg_w = {5'd8, 5'd8};
    hif.rs_e[0 +: 5] = 5'd8; hif.rt_e[5 +: 5] = 5'd8;
    @(negedge clk);
    chk("fwd_w_young_a", hif.fwd_a_e, 6'd4);
    chk("fwd_w_young_b", hif.fwd_b_e, 6'd32);
    step();

    // Register 0 never matches
    clr();
    hif.regwrite_m = 2'b11; hif.regwrite_w = 2'b11;
    @(negedge clk);
    chk("zero_fwd_a_e", hif.fwd_a_e, 6'd0);
    chk("zero_fwd_b_e", hif.fwd_b_e, 6'd0);
    chk("zero_fwd_a_d", hif.fwd_a_d, 4'd0);
    step();

    // Load-use: E lane0 loads r9, D lane1 reads r9 as rt
    clr();
    hif.memtoreg_e = 2'b01; hif.writereg_e[0 +: 5] = 5'd9; hif.rt_d[5 +: 5] = 5'd9;
    @(negedge clk);
    chk("lu_stall_f", hif.stall_f, 1'b1);
    chk("lu_stall_d", hif.stall_d, 1'b1);
    chk("lu_flush_e", hif.flush_e, 1'b1);
    chk("lu_stall_e", hif.stall_e, 1'b0);
    chk("lu_flush_w", hif.flush_w, 1'b0);
    step();
    clr();
    @(negedge clk);
    chk("lu_release", hif.stall_f, 1'b0);
    chk("lu_count",   hif.stall_count, 32'd1);
    step();

    // Branch stall on E producer, then D-forward from M next cycle
    hif.branch_d = 2'b01; hif.rs_d[0 +: 5] = 5'd4;
    hif.regwrite_e = 2'b10; hif.writereg_e[5 +: 5] = 5'd4;
    @(negedge clk);
    chk("bs_stall_f", hif.stall_f, 1'b1);
    chk("bs_flush_e", hif.flush_e, 1'b1);
    step();
    clr();
    hif.branch_d = 2'b01; hif.rs_d[0 +: 5] = 5'd4;
    hif.regwrite_m = 2'b10; hif.writereg_m[5 +: 5] = 5'd4;
    @(negedge clk);
    chk("bs_fwd_a_d", hif.fwd_a_d, 4'd2);
    chk("bs_fwd_nostall", hif.stall_f, 1'b0);
    chk("bs_count", hif.stall_count, 32'd2);
    step();

    // Same E producer without a branch: no stall
    clr();
    hif.rs_d[0 +: 5] = 5'd4;
    hif.regwrite_e = 2'b10; hif.writereg_e[5 +: 5] = 5'd4;
    @(negedge clk);
    chk("nobranch_nostall", hif.stall_f, 1'b0);
    step();

    // Store in M: two stall cycles, then a second store gets two more
    clr();
    hif.memwrite_m = 2'b01;
    hif1.memwrite_m = 2'b01; hif1.memtoreg_m = 2'b10;
    @(negedge clk);
    chk_ms("st1_c0", 1'b1);
    chk("st1_c0_flush_e", hif.flush_e, 1'b0);
    chk("st1_c0_stall_e", hif.stall_e, 1'b1);
    chk("lat1_stall_f", hif1.stall_f, 1'b0);
    chk("lat1_stall_m", hif1.stall_m, 1'b0);
    step();
    @(negedge clk);
    chk_ms("st1_c1", 1'b1);
    chk("lat1_stall_f_c1", hif1.stall_f, 1'b0);
    step();
    @(negedge clk);
    chk_ms("st1_c2", 1'b0);
    chk("st1_count", hif.stall_count, 32'd4);
    chk("lat1_count", hif1.stall_count, 32'd0);
    step();
    clr1();
    @(negedge clk);
    chk_ms("st2_c0", 1'b1);
    step();
    @(negedge clk);
    chk_ms("st2_c1", 1'b1);
    step();
    @(negedge clk);
    chk_ms("st2_c2", 1'b0);
    chk("st2_count", hif.stall_count, 32'd6);
    step();

    // Load in M while load-use is pending: freeze first, bubble after release
    clr();
    hif.memtoreg_m = 2'b01; hif.writereg_m[0 +: 5] = 5'd12;
    hif.memtoreg_e = 2'b01; hif.writereg_e[0 +: 5] = 5'd9; hif.rs_d[0 +: 5] = 5'd9;
    @(negedge clk);
    chk("mslu_c0_stall_f", hif.stall_f, 1'b1);
    chk("mslu_c0_flush_e", hif.flush_e, 1'b0);
    chk("mslu_c0_stall_e", hif.stall_e, 1'b1);
    step();
    @(negedge clk);
    chk("mslu_c1_flush_e", hif.flush_e, 1'b0);
    step();
    @(negedge clk);
    chk("mslu_c2_stall_f", hif.stall_f, 1'b1);
    chk("mslu_c2_flush_e", hif.flush_e, 1'b1);
    chk("mslu_c2_stall_e", hif.stall_e, 1'b0);
    chk("mslu_c2_flush_w", hif.flush_w, 1'b0);
    step();
    clr();
    @(negedge clk);
    chk("mslu_count", hif.stall_count, 32'd9);
    chk("mslu_idle", hif.stall_f, 1'b0);
    step();

    // Reset in WAIT aborts the stall and clears the counter
    hif.memwrite_m = 2'b01;
    @(negedge clk);
    chk_ms("rw_c0", 1'b1);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("rw_rst_stall_f", hif.stall_f, 1'b0);
    chk("rw_rst_count", hif.stall_count, 32'd10);
    step();
    rst = 1'b0;
    clr();
    @(negedge clk);
    chk("rw_after_stall_f", hif.stall_f, 1'b0);
    chk("rw_after_count", hif.stall_count, 32'd0);
    step();
    hif.memwrite_m = 2'b01;
    @(negedge clk);
    chk_ms("rw_new_c0", 1'b1);
    step();
    @(negedge clk);
    chk_ms("rw_new_c1", 1'b1);
    step();
    @(negedge clk);
    chk_ms("rw_new_c2", 1'b0);
    chk("rw_new_count", hif.stall_count, 32'd2);
    step();
    clr();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
